wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//   Multi-cycle controller that computes WORDS*WORD_W-bit add/subtract on one shared WORD_W-bit adder datapath.
//   Operands are captured once, then one word per cycle passes through the adder, LSW first, with a registered carry chain.
//   Sits between an operand producer and a result consumer; valid/ready handshake on both sides.
// PARAMETERS
//   WORDS   4   number of WORD_W slices per operand (>=2)
//   WORD_W  32  width of the shared adder datapath
// PORTS
//   clk        in   1              single clock, all logic on rising edge
//   rst_n      in   1              synchronous reset, active-low
//   in_valid   in   1              operand request valid
//   in_ready   out  1              block can accept operands (high only in IDLE)
//   op_a       in   WORDS*WORD_W   operand A
//   op_b       in   WORDS*WORD_W   operand B
//   op_cin     in   1              carry-in for add (ignored when op_sub=1)
//   op_sub     in   1              1: A-B (B inverted, carry-in forced 1)
//   out_valid  out  1              result valid, held until out_ready
//   out_ready  in   1              consumer accepts result
//   res        out  WORDS*WORD_W   result
//   cout       out  1              carry out of top word (for sub: 1 = no borrow)
//   overflow   out  1              signed overflow of the full-width op
//   busy       out  1              high in RUN or DONE
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state=IDLE, in_ready=1, out_valid=0, busy=0, res=0, cout=0, overflow=0,
//     word counter=0, carry reg=0. Reset mid-RUN/DONE abandons the operation; no result is produced.
//   - FSM: IDLE -> RUN on in_valid&in_ready; RUN -> DONE when counter==WORDS-1; DONE -> IDLE on out_ready.
//   - Accept edge: capture op_a, op_b (B stored as ~op_b if op_sub), carry reg = op_sub ? 1 : op_cin, counter=0.
//   - RUN, word k=counter: adder sums A[k], B'[k], carry reg; at edge res[k]<=sum, carry reg<=adder cout, counter++.
//   - Top word (k=WORDS-1): also latch cout<=adder cout, overflow<=(A.msb==B'.msb)&(sum.msb!=A.msb).
//   - Latency: out_valid rises WORDS edges after the accept edge; in_ready=0, busy=1 during RUN and DONE.
//   - DONE: res/cout/overflow stable while out_valid=1 & out_ready=0 (backpressure, unbounded).
//   - Handshake: out_valid&out_ready at edge -> IDLE; in_ready=1 the next cycle. No accept in the same cycle as
//     result handoff (in_ready is registered-state decode, not combinational on out_ready).
//   - in_valid while in_ready=0 is ignored; inputs not sampled. res only updated in RUN; cleared by reset only.
//   - All arithmetic modulo 2^(WORDS*WORD_W); intermediate carry is exactly the adder carry-out of the prior word.
// TESTING (WORDS=4, WORD_W=32)
//   1. A=all 1s, B=1, cin=0, sub=0 -> res=0, cout=1, overflow=0; out_valid 4 edges after accept.
//   2. A=0, B=1, sub=1 -> res=all 1s (128'hFFFF...F), cout=0 (borrow), overflow=0.
//   3. A=128'h7FFF...F, B=1, add -> res=128'h8000...0, cout=0, overflow=1; carry ripples across all 4 words.
//   4. Carry-in only: A=32'hFFFFFFFF in word0 only, B=0, cin=1 -> res=128'h1_0000_0000, cout=0.
//   5. Backpressure: hold out_ready=0 5 cycles after out_valid -> res/cout/overflow unchanged, in_ready=0;
//      in_valid pulsed meanwhile is dropped; out_ready=1 -> IDLE, in_ready=1 next cycle.
//   6. Reset mid-RUN (after 2 words) -> next cycle out_valid=0, in_ready=1, res=0; a new op completes correctly.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-word add/subtract sequencer: one WORD_W-bit adder is reused across WORDS
// slices, LSW first, with a registered carry between slices.
module wide_add_sequencer #(
  parameter int WORDS  = 4,
  parameter int WORD_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] op_a,
  input  logic [WORDS*WORD_W-1:0] op_b,
  input  logic                    op_cin,
  input  logic                    op_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] res,
  output logic                    cout,
  output logic                    overflow,
  output logic                    busy
);

  localparam int CNT_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state_r;
  state_t                         state_next_s;
  logic [WORDS-1:0][WORD_W-1:0]   a_r;
  logic [WORDS-1:0][WORD_W-1:0]   b_r;
  logic [WORDS-1:0][WORD_W-1:0]   res_r;
  logic [CNT_W-1:0]               cnt_r;
  logic                           carry_r;
  logic                           cout_r;
  logic                           ovf_r;
  logic                           in_ready_r;
  logic                           out_valid_r;
  logic                           busy_r;
  logic                           in_ready_nxt_s;
  logic                           out_valid_nxt_s;
  logic                           busy_nxt_s;
  logic [WORD_W:0]                sum_s;
  logic                           last_word_s;

  assign last_word_s = (cnt_r == CNT_W'(WORDS - 1));

  // Shared adder slice for the word selected by the counter.
  always_comb begin
    sum_s = {1'b0, a_r[cnt_r]} + {1'b0, b_r[cnt_r]} + {{WORD_W{1'b0}}, carry_r};
  end

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      RUN: begin
        if (last_word_s) state_next_s = DONE;
        else             state_next_s = RUN;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered above.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    busy_nxt_s      = 1'b0;
    case (state_next_s)
      IDLE: begin
        in_ready_nxt_s = 1'b1;
      end
      RUN: begin
        busy_nxt_s = 1'b1;
      end
      DONE: begin
        busy_nxt_s      = 1'b1;
        out_valid_nxt_s = 1'b1;
      end
      default: begin
        in_ready_nxt_s = 1'b1;
      end
    endcase
  end

  // Operand capture and word-serial accumulation into the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= op_a;
            b_r     <= op_sub ? ~op_b : op_b;
            carry_r <= op_sub ? 1'b1 : op_cin;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          res_r[cnt_r] <= sum_s[WORD_W-1:0];
          carry_r      <= sum_s[WORD_W];
          cnt_r        <= cnt_r + CNT_W'(1);
          // Signed overflow: like-signed operands produced an opposite-signed sum.
          if (last_word_s) begin
            cout_r <= sum_s[WORD_W];
            ovf_r  <= (a_r[cnt_r][WORD_W-1] == b_r[cnt_r][WORD_W-1]) &&
                      (sum_s[WORD_W-1] != a_r[cnt_r][WORD_W-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign res       = res_r;
  assign cout      = cout_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (WORDS=4, WORD_W=32): vector table plus
// backpressure and mid-run reset sequences.
module tb_wide_add_sequencer;

  localparam int WORDS  = 4;
  localparam int WORD_W = 32;
  localparam int TW     = WORDS * WORD_W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] op_a;
  logic [TW-1:0] op_b;
  logic          op_cin;
  logic          op_sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] res;
  logic          cout;
  logic          overflow;
  logic          busy;

  int n_vec;
  int n_err;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic          sub;
    logic [TW-1:0] exp_res;
    logic          exp_cout;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[8];

  wide_add_sequencer #(.WORDS(WORDS), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .cout(cout),
    .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, then wait (bounded) for out_valid; returns edges after accept.
  task automatic start_and_wait(input vec_t v, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    op_a = v.a; op_b = v.b; op_cin = v.cin; op_sub = v.sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
    lat = 0;
    check("run_busy", {126'd0, busy, in_ready}, {126'd0, 1'b1, 1'b0});
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    check({tag, "_lat"}, TW'(lat), TW'(4));
    check({tag, "_res"}, res, v.exp_res);
    check({tag, "_cout_ovf"}, {126'd0, cout, overflow}, {126'd0, v.exp_cout, v.exp_ovf});
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_handoff"}, {125'd0, in_ready, out_valid, busy}, {125'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    int lat;
    logic [TW-1:0] held_res;
    logic          held_cout;
    logic          held_ovf;
    vec_t          v;

    n_vec = 0;
    n_err = 0;

    vecs[0] = '{{TW{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0};
    vecs[1] = '{128'd0, 128'd1, 1'b0, 1'b1, {TW{1'b1}}, 1'b0, 1'b0};
    vecs[2] = '{{1'b0, {(TW-1){1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, {(TW-1){1'b0}}}, 1'b0, 1'b1};
    vecs[3] = '{128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd0, 1'b1, 1'b0,
                128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[4] = '{128'd5, 128'd3, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0};
    vecs[5] = '{{1'b1, {(TW-1){1'b0}}}, 128'd1, 1'b0, 1'b1, {1'b0, {(TW-1){1'b1}}}, 1'b1, 1'b1};
    vecs[6] = '{128'd10, 128'd3, 1'b1, 1'b1, 128'd7, 1'b1, 1'b0};
    vecs[7] = '{128'h0000_0001_FFFF_FFFF_0000_0000_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                128'h0000_0001_FFFF_FFFF_0000_0001_0000_0000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
    tick();
    tick();
    check("reset_ctrl", {124'd0, in_ready, out_valid, busy, 1'b0}, {124'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_res", res, 128'd0);
    check("reset_flags", {126'd0, cout, overflow}, 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      start_and_wait(vecs[i], lat);
      check_result($sformatf("vec%0d", i), vecs[i], lat);
      handoff($sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, a stray request is dropped.
    start_and_wait(vecs[2], lat);
    check_result("bp", vecs[2], lat);
    held_res = res; held_cout = cout; held_ovf = overflow;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        op_a = 128'd77; op_b = 128'd11; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check($sformatf("bp_hold%0d_res", c), res, vecs[2].exp_res);
      check($sformatf("bp_hold%0d_ctl", c),
            {123'd0, in_ready, out_valid, busy, cout, overflow},
            {123'd0, 1'b0, 1'b1, 1'b1, vecs[2].exp_cout, vecs[2].exp_ovf});
    end
    in_valid = 1'b0; op_a = '0; op_b = '0;
    handoff("bp");
    tick();
    check("bp_idle_stays", {126'd0, in_ready, busy}, {126'd0, 1'b1, 1'b0});

    // Reset after two words of a run abandons it.
    v = vecs[0];
    op_a = v.a; op_b = v.b; op_cin = v.cin; op_sub = v.sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_reset_ctl", {125'd0, out_valid, in_ready, busy}, {125'd0, 1'b0, 1'b1, 1'b0});
    check("mid_reset_res", res, 128'd0);
    start_and_wait(vecs[2], lat);
    check_result("post_reset", vecs[2], lat);
    handoff("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
